// File: rtl/std_wrap_pkg.sv
// Purpose: shared types and constants for the std_wrap clocking cells.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package std_wrap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } ckdiv_state_e;

  // Smallest ratio that still yields one high and one low cycle.
  localparam int CKDIV_MIN_RATIO = 2;

endpackage

// File: rtl/std_wrap_ckdiv_cnt.sv
// Purpose: period position counter for the clock divider, wraps at ratio-1.
// Latency: cnt updates on the edge after en; wrap is combinational from cnt.
// Backpressure: none; clear has priority over counting.
module std_wrap_ckdiv_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] ratio,
  output logic [DIV_W-1:0] cnt,
  output logic             wrap
);

  // Last cycle of the current period.
  assign wrap = (cnt == ratio - DIV_W'(1));

  // Count through the period, returning to zero after the last cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/std_wrap_ckdiv.sv
// Purpose: glitch-free programmable integer clock divider with period tick.
// Latency: clk_o/tick_o rise on the same edge en_i is first sampled in IDLE.
// Backpressure: cfg_rdy_o low while a ratio is pending or in reset.
module std_wrap_ckdiv #(
  parameter int DIV_W     = 8,
  parameter int RST_RATIO = 2,
  parameter bit INV_OUT   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cfg_vld_i,
  input  logic [DIV_W-1:0] cfg_ratio_i,
  output logic             cfg_rdy_o,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
);
  import std_wrap_pkg::*;

  ckdiv_state_e     state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] r_cur, r_pend, cfg_ratio_clamp;
  logic [DIV_W:0]   high_len;
  logic             pend, lvl, lvl_nxt, tick, tick_nxt;
  logic             wrap, cfg_xfer, running;

  assign running   = (state != IDLE);
  assign cfg_rdy_o = ~pend & ~rst_i;
  assign cfg_xfer  = cfg_vld_i & cfg_rdy_o;

  // Ratios below the minimum would give a degenerate (non-toggling) output.
  assign cfg_ratio_clamp = (cfg_ratio_i < DIV_W'(CKDIV_MIN_RATIO)) ?
                           DIV_W'(CKDIV_MIN_RATIO) : cfg_ratio_i;

  // High phase is the longer half for odd ratios.
  assign high_len = ({1'b0, r_cur} + (DIV_W+1)'(1)) >> 1;
  assign cnt_nxt  = wrap ? '0 : cnt + DIV_W'(1);

  std_wrap_ckdiv_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (~running),
    .en    (running),
    .ratio (r_cur),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Next state plus next level/tick; stopping only ever happens on a wrap.
  always_comb begin
    state_nxt = state;
    lvl_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (en_i) begin
          state_nxt = RUN;
          lvl_nxt   = 1'b1;
          tick_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (!en_i) state_nxt = STOP;
        lvl_nxt  = ({1'b0, cnt_nxt} < high_len);
        tick_nxt = (cnt_nxt == '0);
      end
      STOP: begin
        if (wrap && !en_i) begin
          state_nxt = IDLE;
        end else begin
          if (en_i) state_nxt = RUN;
          lvl_nxt  = ({1'b0, cnt_nxt} < high_len);
          tick_nxt = (cnt_nxt == '0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and tick flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      tick  <= 1'b0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
    end
  end

  // Single dedicated flop for the divided clock level (generated-clock source).
  always_ff @(posedge clk_i) begin
    if (rst_i) lvl <= 1'b0;
    else       lvl <= lvl_nxt;
  end

  // Ratio capture: direct in IDLE, otherwise staged and swapped in at a wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cur  <= DIV_W'(RST_RATIO);
      r_pend <= DIV_W'(RST_RATIO);
      pend   <= 1'b0;
    end else if (!running) begin
      if (cfg_xfer) r_cur <= cfg_ratio_clamp;
    end else begin
      if (wrap && pend) begin
        r_cur <= r_pend;
        pend  <= 1'b0;
      end
      if (cfg_xfer) begin
        r_pend <= cfg_ratio_clamp;
        pend   <= 1'b1;
      end
    end
  end

  assign clk_o  = lvl ^ INV_OUT;
  assign tick_o = tick;
  assign busy_o = running;

endmodule
